// File: rtl/pcf8591_dac_sequencer_if.sv
// Handshake bundle between the sample source / I2C byte transmitter and the
// PCF8591 DAC sequencer. The sequencer connects through the slave modport.
`timescale 1ns/1ps

interface pcf8591_dac_sequencer_if;
    logic        enable;
    logic [7:0]  sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  tx_word;
    logic        tx_ready;
    logic        tx_reset;
    logic        busy;
    logic        underrun;
    logic [15:0] underrun_count;

    modport master (
        output enable, sample_data, sample_valid, tx_ready,
        input  sample_ready, tx_word, tx_reset, busy, underrun, underrun_count
    );

    modport slave (
        input  enable, sample_data, sample_valid, tx_ready,
        output sample_ready, tx_word, tx_reset, busy, underrun, underrun_count
    );
endinterface

// File: rtl/pcf8591_dac_sequencer.sv
// Sequences address, control and sample bytes into a free-running I2C byte
// transmitter for a PCF8591 DAC. Define PCF8591_SEQ_UNDERRUN_CNT_EN to build the underrun counter.
`timescale 1ns/1ps

module pcf8591_dac_sequencer #(
    parameter logic [2:0] DEV_ADDR     = 3'b000,
    parameter logic [7:0] CTRL_BYTE    = 8'h40,
    parameter int         FIFO_AW      = 2,
    parameter int         DRAIN_CYCLES = 14
) (
    input logic                     clk,
    input logic                     reset_n,
    pcf8591_dac_sequencer_if.slave  bus
);

    localparam logic [7:0] ADDR_BYTE = {4'b1001, DEV_ADDR, 1'b0};
    localparam int         DEPTH     = 1 << FIFO_AW;
    localparam int         DCW       = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CTRL,
        S_DATA,
        S_DRAIN
    } state_e;

    state_e           state_q;
    logic [7:0]       tx_word_q;
    logic             tx_reset_q;
    logic             busy_q;
    logic             underrun_q;
    logic [DCW-1:0]   drain_cnt_q;

    logic [7:0]       mem_q [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q;
    logic [FIFO_AW:0] rd_ptr_q;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic byte_step;
    logic underrun_hit;

    // NOTE: every signal gets a value before any condition so no latch is inferred.
    always_comb begin
        fifo_empty   = (wr_ptr_q == rd_ptr_q);
        fifo_full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
        push         = bus.sample_valid && !fifo_full;
        byte_step    = bus.tx_ready && bus.enable &&
                       ((state_q == S_CTRL) || (state_q == S_DATA));
        pop          = byte_step && !fifo_empty;
        underrun_hit = byte_step && fifo_empty;
    end

    // NOTE: sample storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= bus.sample_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (FIFO_AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (FIFO_AW+1)'(1);
        end
    end

    // tx_word only moves on a byte-consumed pulse or on return to IDLE, never mid-byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            tx_word_q   <= ADDR_BYTE;
            tx_reset_q  <= 1'b1;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            underrun_q <= underrun_hit;
            case (state_q)
                S_IDLE: begin
                    if (bus.enable && !fifo_empty) begin
                        state_q    <= S_ADDR;
                        tx_reset_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (bus.tx_ready) begin
                        if (bus.enable) begin
                            state_q   <= S_CTRL;
                            tx_word_q <= CTRL_BYTE;
                        end else begin
                            state_q     <= S_DRAIN;
                            drain_cnt_q <= DRAIN_LOAD;
                        end
                    end
                end
                S_CTRL, S_DATA: begin
                    if (bus.tx_ready) begin
                        if (bus.enable) begin
                            state_q <= S_DATA;
                            if (pop) tx_word_q <= mem_q[rd_ptr_q[FIFO_AW-1:0]];
                        end else begin
                            state_q     <= S_DRAIN;
                            drain_cnt_q <= DRAIN_LOAD;
                        end
                    end
                end
                S_DRAIN: begin
                    // Let the transmitter finish the last bit/ACK before parking the bus.
                    if (drain_cnt_q == '0) begin
                        state_q    <= S_IDLE;
                        tx_reset_q <= 1'b1;
                        busy_q     <= 1'b0;
                        tx_word_q  <= ADDR_BYTE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - DCW'(1);
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    tx_reset_q <= 1'b1;
                    busy_q     <= 1'b0;
                    tx_word_q  <= ADDR_BYTE;
                end
            endcase
        end
    end

`ifdef PCF8591_SEQ_UNDERRUN_CNT_EN
    logic [15:0] underrun_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_count_q <= 16'h0000;
        end else if (underrun_hit && (underrun_count_q != 16'hFFFF)) begin
            underrun_count_q <= underrun_count_q + 16'd1;
        end
    end

    assign bus.underrun_count = underrun_count_q;
`else
    assign bus.underrun_count = 16'h0000;
`endif

    assign bus.sample_ready = !fifo_full;
    assign bus.tx_word      = tx_word_q;
    assign bus.tx_reset     = tx_reset_q;
    assign bus.busy         = busy_q;
    assign bus.underrun     = underrun_q;

endmodule
